// File: rtl/control_pkg.sv
// control_pkg: shared constants for the lab-processor control unit.
//   - opcode values (IR[15:12])
//   - FSM state encodings (exported on StateO for the hex displays)
//   - ALU operation selects
//   - exec_state(): maps an opcode to its execute state
package control_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // Unknown opcodes fall through to NOOP so that a corrupt ROM word
    // cannot wedge the sequencer.
    function automatic state_t exec_state(input logic [3:0] op);
        state_t s;
        case (op)
            OP_NOOP:  s = S_NOOP;
            OP_STORE: s = S_STORE;
            OP_LOAD:  s = S_LOAD_A;
            OP_ADD:   s = S_ADD;
            OP_SUB:   s = S_SUB;
            OP_HALT:  s = S_HALT;
            default:  s = S_NOOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (PC -> 0)
//   inc_en in   advance PC by one this cycle
//   pc     out  current PC; wraps from all-ones to zero
module pc_counter #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_en,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Natural modulo-2^PC_W wrap of the adder gives 255 -> 0.
    always_comb begin
        pc_d = pc_q;
        if (inc_en) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// control_unit: instruction-sequencing FSM for the 16-bit lab processor.
// Owns PC and IR, fetches from a combinational ROM, decodes, and drives
// the data-RAM / register-file / ALU control strobes.
//
// Ports:
//   Clk, Reset            clock, async active-high reset
//   InstrData             ROM word at address PC_Out
//   PC_Out, IR_Out        current PC and instruction
//   StateO                current state code
//   D_Addr, D_Wr          data-RAM address and write strobe
//   RF_s                  RF write source (0 = ALU, 1 = RAM)
//   RF_W_Addr, RF_W_en    RF write port
//   RF_Ra_Addr, RF_Rb_Addr RF read ports
//   ALU_s0                ALU op select
//
// state    | meaning
// ---------+------------------------------------------------
// INIT     | post-reset, one idle cycle
// FETCH    | IR <= ROM[PC], PC <= PC + 1
// DECODE   | pick execute state from opcode, no strobes
// NOOP     | no-op (also illegal opcodes)
// LOAD_A   | RAM address valid, synchronous RAM read in flight
// LOAD_B   | RAM data written into RF
// STORE    | one-cycle RAM write of RF[Ra] via ALU pass
// ADD      | RF[Wa] <= RF[Ra] + RF[Rb]
// SUB      | RF[Wa] <= RF[Ra] - RF[Rb]
// HALT     | parked until Reset
module control_unit
    import control_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int IR_W     = 16,
    parameter int D_ADDR_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [IR_W-1:0]     InstrData,
    output logic [PC_W-1:0]     PC_Out,
    output logic [IR_W-1:0]     IR_Out,
    output logic [3:0]          StateO,
    output logic [D_ADDR_W-1:0] D_Addr,
    output logic                D_Wr,
    output logic                RF_s,
    output logic [3:0]          RF_W_Addr,
    output logic                RF_W_en,
    output logic [3:0]          RF_Ra_Addr,
    output logic [3:0]          RF_Rb_Addr,
    output logic [2:0]          ALU_s0
);

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [D_ADDR_W-1:0] d_addr_q, d_addr_d;
    logic                d_wr_q, d_wr_d;
    logic                rf_s_q, rf_s_d;
    logic [3:0]          rf_w_addr_q, rf_w_addr_d;
    logic                rf_w_en_q, rf_w_en_d;
    logic [3:0]          rf_ra_q, rf_ra_d;
    logic [3:0]          rf_rb_q, rf_rb_d;
    logic [2:0]          alu_q, alu_d;
    logic                fetch;

    assign fetch = (state_q == S_FETCH);

    pc_counter #(.PC_W(PC_W)) u_pc (
        .clk    (Clk),
        .rst    (Reset),
        .inc_en (fetch),
        .pc     (PC_Out)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = fetch ? InstrData : ir_q;

        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = exec_state(ir_q[IR_W-1 -: 4]);
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered; the flop then presents them for the whole of that state.
        d_addr_d    = '0;
        d_wr_d      = 1'b0;
        rf_s_d      = 1'b0;
        rf_w_addr_d = '0;
        rf_w_en_d   = 1'b0;
        rf_ra_d     = '0;
        rf_rb_d     = '0;
        alu_d       = ALU_PASS;

        case (state_d)
            S_LOAD_A, S_LOAD_B: begin
                d_addr_d    = ir_d[11:4];
                rf_w_addr_d = ir_d[3:0];
                rf_s_d      = 1'b1;
                rf_w_en_d   = (state_d == S_LOAD_B);
            end
            S_STORE: begin
                rf_ra_d  = ir_d[11:8];
                d_addr_d = ir_d[7:0];
                alu_d    = ALU_PASS;
                d_wr_d   = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_d     = ir_d[11:8];
                rf_rb_d     = ir_d[7:4];
                rf_w_addr_d = ir_d[3:0];
                alu_d       = (state_d == S_ADD) ? ALU_ADD : ALU_SUB;
                rf_w_en_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_INIT;
            ir_q        <= '0;
            d_addr_q    <= '0;
            d_wr_q      <= 1'b0;
            rf_s_q      <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_en_q   <= 1'b0;
            rf_ra_q     <= '0;
            rf_rb_q     <= '0;
            alu_q       <= ALU_PASS;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            d_addr_q    <= d_addr_d;
            d_wr_q      <= d_wr_d;
            rf_s_q      <= rf_s_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_en_q   <= rf_w_en_d;
            rf_ra_q     <= rf_ra_d;
            rf_rb_q     <= rf_rb_d;
            alu_q       <= alu_d;
        end
    end

    assign IR_Out     = ir_q;
    assign StateO     = state_q;
    assign D_Addr     = d_addr_q;
    assign D_Wr       = d_wr_q;
    assign RF_s       = rf_s_q;
    assign RF_W_Addr  = rf_w_addr_q;
    assign RF_W_en    = rf_w_en_q;
    assign RF_Ra_Addr = rf_ra_q;
    assign RF_Rb_Addr = rf_rb_q;
    assign ALU_s0     = alu_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level reference model expands each
// ROM word into its expected per-cycle trace, compared at the falling edge.
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] InstrData;
    logic [7:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  StateO;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [256];

    assign InstrData = rom[PC_Out];

    always #5 Clk = ~Clk;

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .InstrData  (InstrData),
        .PC_Out     (PC_Out),
        .IR_Out     (IR_Out),
        .StateO     (StateO),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected cycle; c_* flags mark fields the instruction actually defines.
    typedef struct {
        logic [3:0]  st;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        dw, we;
        logic [7:0]  da;
        logic        rs;
        logic [3:0]  wa, ra, rb;
        logic [2:0]  alu;
        bit          c_da, c_rs, c_wa, c_ra, c_rb, c_alu;
    } exp_t;

    logic [7:0]  m_pc;
    logic [15:0] m_ir;

    function automatic exp_t quiet(input logic [3:0] st);
        exp_t e;
        e.st = st; e.pc = m_pc; e.ir = m_ir;
        e.dw = 1'b0; e.we = 1'b0; e.da = '0; e.rs = 1'b0;
        e.wa = '0; e.ra = '0; e.rb = '0; e.alu = '0;
        e.c_da = 0; e.c_rs = 0; e.c_wa = 0; e.c_ra = 0; e.c_rb = 0; e.c_alu = 0;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check_eq("state", StateO, e.st);
        check_eq("pc", PC_Out, e.pc);
        check_eq("ir", IR_Out, e.ir);
        check_eq("d_wr", D_Wr, e.dw);
        check_eq("rf_w_en", RF_W_en, e.we);
        if (e.c_da)  check_eq("d_addr", D_Addr, e.da);
        if (e.c_rs)  check_eq("rf_s", RF_s, e.rs);
        if (e.c_wa)  check_eq("rf_w_addr", RF_W_Addr, e.wa);
        if (e.c_ra)  check_eq("rf_ra", RF_Ra_Addr, e.ra);
        if (e.c_rb)  check_eq("rf_rb", RF_Rb_Addr, e.rb);
        if (e.c_alu) check_eq("alu_s0", ALU_s0, e.alu);
        check_eq("no_x", $isunknown({PC_Out, IR_Out, StateO, D_Addr, D_Wr, RF_s,
                 RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0}), 0);
        check_eq("wr_excl", D_Wr & RF_W_en, 0);
    endtask

    task automatic step(input exp_t e);
        @(negedge Clk);
        compare(e);
    endtask

    // Assert reset asynchronously partway through the low phase; everything
    // must clear before the next clock edge.
    task automatic reset_dut();
        exp_t e;
        #2 Reset = 1'b1;
        #1;
        m_pc = 8'd0;
        m_ir = 16'd0;
        e = quiet(4'd0);
        e.c_da = 1; e.c_rs = 1; e.c_wa = 1; e.c_ra = 1; e.c_rb = 1; e.c_alu = 1;
        compare(e);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic run_instr(output bit halted);
        exp_t e;
        logic [15:0] w;
        logic [3:0]  op;
        halted = 1'b0;
        step(quiet(4'd1));
        w    = rom[m_pc];
        m_pc = m_pc + 8'd1;
        m_ir = w;
        op   = w[15:12];
        step(quiet(4'd2));
        case (op)
            4'd2: begin
                e = quiet(4'd4);
                e.da = w[11:4]; e.wa = w[3:0]; e.rs = 1'b1;
                e.c_da = 1; e.c_wa = 1; e.c_rs = 1;
                step(e);
                e.st = 4'd5; e.we = 1'b1;
                step(e);
            end
            4'd1: begin
                e = quiet(4'd6);
                e.ra = w[11:8]; e.da = w[7:0]; e.alu = 3'd0; e.dw = 1'b1;
                e.c_ra = 1; e.c_da = 1; e.c_alu = 1;
                step(e);
            end
            4'd3, 4'd4: begin
                e = quiet(op == 4'd3 ? 4'd7 : 4'd8);
                e.ra = w[11:8]; e.rb = w[7:4]; e.wa = w[3:0];
                e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
                e.rs = 1'b0; e.we = 1'b1;
                e.c_ra = 1; e.c_rb = 1; e.c_wa = 1; e.c_alu = 1; e.c_rs = 1;
                step(e);
            end
            4'd5: begin
                step(quiet(4'd9));
                halted = 1'b1;
            end
            default: step(quiet(4'd3));
        endcase
    endtask

    initial begin
        bit h;
        logic [15:0] w;
        int op;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h21B5;
        rom[1] = 16'h3247;
        rom[2] = 16'h1780;
        rom[3] = 16'hF000;
        rom[4] = 16'h5000;

        reset_dut();

        // Run LOAD up to LOAD_B, then reset mid-instruction.
        run_instr(h);
        reset_dut();

        // Directed program from a clean start, ending in HALT.
        for (int i = 0; i < 5; i++) begin
            run_instr(h);
            if (h) break;
        end
        check_eq("halt_reached", h, 1);
        for (int i = 0; i < 22; i++) step(quiet(4'd9));

        // Random program with every opcode except HALT; long enough to wrap PC.
        for (int i = 0; i < 256; i++) begin
            w  = 16'($urandom);
            op = $urandom_range(0, 14);
            if (op >= 5) op++;
            w[15:12] = 4'(op);
            rom[i] = w;
        end
        reset_dut();
        for (int i = 0; i < 300; i++) run_instr(h);

        // NOOP-only program: PC walks to 255 and wraps to 0.
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            w[15:12] = 4'd0;
            rom[i] = w;
        end
        reset_dut();
        for (int i = 0; i < 256; i++) run_instr(h);
        check_eq("pc_wrap", PC_Out, 0);
        run_instr(h);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
